// File: rtl/alu_dest_collector_pkg.sv
// Shared ALU wavefront constants and the destination collector state encoding.
package alu_dest_collector_pkg;

  localparam int WF_LANES       = 64;
  localparam int LANES_PER_PASS = 16;
  localparam int NUM_PASSES     = 4;
  localparam int DATA_W         = 32;
  localparam int PASS_W         = $clog2(NUM_PASSES);
  localparam int BEAT_DATA_W    = LANES_PER_PASS * DATA_W;
  localparam int WORD_DATA_W    = WF_LANES * DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } collect_state_t;

  function automatic logic [NUM_PASSES-1:0] slice_onehot(input logic [PASS_W-1:0] idx);
    logic [NUM_PASSES-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_PASSES; i++) begin
      if (idx == PASS_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/alu_dest_collector_if.sv
// Beat input / completed-word output bundle between the ALU, the collector and retire.
interface alu_dest_collector_if;
  import alu_dest_collector_pkg::*;

  logic                      alu_result_valid;
  logic [BEAT_DATA_W-1:0]    alu_dest_data;
  logic [LANES_PER_PASS-1:0] alu_dest_vcc;
  logic [LANES_PER_PASS-1:0] alu_dest_exec;
  logic                      collect_flush;
  logic                      out_ready;
  logic                      out_valid;
  logic [WORD_DATA_W-1:0]    dest_data;
  logic [WF_LANES-1:0]       dest_vcc;
  logic [WF_LANES-1:0]       dest_exec_mask;
  logic                      collect_busy;
  logic [PASS_W-1:0]         pass_cnt;
  logic                      drop_err;

  modport master (
    output alu_result_valid, alu_dest_data, alu_dest_vcc, alu_dest_exec,
           collect_flush, out_ready,
    input  out_valid, dest_data, dest_vcc, dest_exec_mask,
           collect_busy, pass_cnt, drop_err
  );

  modport slave (
    input  alu_result_valid, alu_dest_data, alu_dest_vcc, alu_dest_exec,
           collect_flush, out_ready,
    output out_valid, dest_data, dest_vcc, dest_exec_mask,
           collect_busy, pass_cnt, drop_err
  );

endinterface

// File: rtl/alu_dest_collector_slice_write_reg.sv
// Register file of SLICES slices, each LANES x LANE_W wide, written by a one-hot slice enable.
module slice_write_reg #(
  parameter int LANE_W = 32,
  parameter int LANES  = 16,
  parameter int SLICES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SLICES-1:0]            we,
  input  logic [LANES*LANE_W-1:0]      wdata,
  output logic [SLICES*LANES*LANE_W-1:0] q
);

  localparam int SLICE_W = LANES * LANE_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int s = 0; s < SLICES; s++) begin
        if (we[s]) q[s*SLICE_W +: SLICE_W] <= wdata;
      end
    end
  end

endmodule

// File: rtl/alu_dest_collector.sv
// Gathers four 16-lane ALU result beats into one 64-lane word and hands it to retire
// over a valid/ready handshake, flagging beats that arrive while a word is still held.
module alu_dest_collector
  import alu_dest_collector_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  alu_dest_collector_if.slave  bus
);

  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  collect_state_t      state;
  logic [PASS_W-1:0]   pass_cnt;
  logic                out_valid;
  logic                drop_err;
  logic                accept;
  logic [NUM_PASSES-1:0] slice_we;

  logic [WORD_DATA_W-1:0] data_q;
  logic [WF_LANES-1:0]    vcc_q;
  logic [WF_LANES-1:0]    exec_q;

  // A beat is stored only when it will count toward a word: flush wins in COLLECT,
  // and in HOLD it needs the same-cycle handshake to become slice 0 of the next word.
  always_comb begin
    accept = 1'b0;
    unique case (state)
      IDLE:    accept = bus.alu_result_valid;
      COLLECT: accept = bus.alu_result_valid && !bus.collect_flush;
      HOLD:    accept = bus.alu_result_valid && bus.out_ready;
      default: accept = 1'b0;
    endcase
  end

  assign slice_we = accept ? slice_onehot(pass_cnt) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pass_cnt  <= '0;
      out_valid <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.alu_result_valid) begin
            pass_cnt <= PASS_W'(1);
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.collect_flush) begin
            pass_cnt <= '0;
            state    <= IDLE;
          end else if (bus.alu_result_valid) begin
            if (pass_cnt == LAST_PASS) begin
              pass_cnt  <= '0;
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              pass_cnt <= pass_cnt + PASS_W'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            if (bus.alu_result_valid) begin
              pass_cnt <= PASS_W'(1);
              state    <= COLLECT;
            end else begin
              state <= IDLE;
            end
          end else if (bus.alu_result_valid) begin
            drop_err <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          pass_cnt  <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  slice_write_reg #(.LANE_W(DATA_W), .LANES(LANES_PER_PASS), .SLICES(NUM_PASSES)) u_data_reg (
    .clk   (clk),
    .rst   (rst),
    .we    (slice_we),
    .wdata (bus.alu_dest_data),
    .q     (data_q)
  );

  slice_write_reg #(.LANE_W(1), .LANES(LANES_PER_PASS), .SLICES(NUM_PASSES)) u_vcc_reg (
    .clk   (clk),
    .rst   (rst),
    .we    (slice_we),
    .wdata (bus.alu_dest_vcc),
    .q     (vcc_q)
  );

  slice_write_reg #(.LANE_W(1), .LANES(LANES_PER_PASS), .SLICES(NUM_PASSES)) u_exec_reg (
    .clk   (clk),
    .rst   (rst),
    .we    (slice_we),
    .wdata (bus.alu_dest_exec),
    .q     (exec_q)
  );

  assign bus.out_valid      = out_valid;
  assign bus.dest_data      = data_q;
  assign bus.dest_vcc       = vcc_q;
  assign bus.dest_exec_mask = exec_q;
  assign bus.collect_busy   = (state != IDLE);
  assign bus.pass_cnt       = pass_cnt;
  assign bus.drop_err       = drop_err;

endmodule

// File: doc/alu_dest_collector.md
Name: alu_dest_collector

Overview:
- Downstream neighbour of the ALU source shift register.
- The ALU produces 16 lanes of results per cycle, one 512-bit slice per pass, over 4 passes per 64-lane wavefront instruction.
- This block gathers the 4 slices of data, VCC bits and exec bits into full 2048/64/64-bit words.
- It presents each completed word to the retire/writeback stage with a valid/ready handshake, and flags result beats it had to drop.

Parameters:
- LANES_PER_PASS, 16, lanes delivered per ALU beat
- NUM_PASSES, 4, beats per wavefront (64 lanes total)
- DATA_W, 32, bits per lane

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- alu_result_valid  input  1  ALU result beat present this cycle
- alu_dest_data  input  512  16 lanes x 32-bit results, lane 0 in bits [31:0]
- alu_dest_vcc  input  16  per-lane VCC/carry result bits
- alu_dest_exec  input  16  per-lane exec bits that travelled with the beat
- collect_flush  input  1  abandon the partial wavefront
- out_ready  input  1  retire stage accepts the completed word
- out_valid  output  1  completed 64-lane word available
- dest_data  output  2048  assembled results
- dest_vcc  output  64  assembled VCC bits
- dest_exec_mask  output  64  assembled exec bits
- collect_busy  output  1  high in COLLECT or HOLD
- pass_cnt  output  2  index of the next slice to be written
- drop_err  output  1  sticky flag: a result beat was dropped

Behaviour:
- Reset: synchronous on rst=1. Drives out_valid=0, dest_data=0, dest_vcc=0, dest_exec_mask=0, pass_cnt=0, drop_err=0 and state=IDLE. Reset overrides every other input, including mid-collection and during HOLD.
- Slice mapping: beat k writes the following slices.
  - dest_data[512k+511 : 512k]
  - dest_vcc[16k+15 : 16k]
  - dest_exec_mask[16k+15 : 16k]
  - This matches the source shift order: lanes 0-15 first.
- Data pass-through: data is stored as produced. No masking by the exec bits; the exec mask is carried alongside for writeback.
- FSM states: IDLE, COLLECT, HOLD.
- IDLE:
  - A valid beat writes slice 0, sets pass_cnt=1 and moves to COLLECT.
  - Otherwise the block stays in IDLE.
- COLLECT:
  - Each valid beat writes slice pass_cnt and increments pass_cnt.
  - A beat written at pass_cnt=NUM_PASSES-1 wraps pass_cnt to 0, moves to HOLD, and registers out_valid=1.
  - Non-valid cycles (gaps) are allowed; state and pass_cnt hold.
- HOLD:
  - out_valid=1 and the outputs are stable until the handshake completes.
  - out_ready=1 with no valid beat: out_valid=0 next cycle, go to IDLE.
  - out_ready=1 with a valid beat in the same cycle: the beat is written as slice 0 of the next wavefront, pass_cnt=1, state goes to COLLECT, out_valid=0. No bubble.
  - Valid beat with out_ready=0: the beat is dropped, outputs are unchanged, and drop_err is set.
- Latency: out_valid rises the cycle after the 4th beat. Minimum period is 4 cycles per wavefront with back-to-back beats and out_ready held high.
- collect_flush:
  - In COLLECT: go to IDLE with pass_cnt=0. Stale slices are left in place; they are overwritten before the next out_valid.
  - In IDLE: no effect.
  - In HOLD: no effect. A completed word is never discarded.
  - If flush and a valid beat coincide in COLLECT, the flush wins and the beat is discarded without setting drop_err.
- drop_err is sticky until rst.
- collect_busy = (state != IDLE).
- Out-of-contract input: alu_dest_* are ignored whenever alu_result_valid=0.

Decomposition:
- Shared ALU package holds:
  - the wavefront constants WF_LANES=64, LANES_PER_PASS and NUM_PASSES;
  - the DATA_W lane width;
  - the FSM state encoding (IDLE=2'd0, COLLECT=2'd1, HOLD=2'd2).
- One natural sub-module, slice_write_reg: a parameterised register file with a one-hot slice write-enable. It is instantiated three times, at widths 32 (data), 1 (vcc) and 1 (exec).

Test Plan:
- Four consecutive beats with data lane values 0x1000+lane, vcc=16'hA5A5 per beat and exec=16'hFFFF, with out_ready=1. Required response: out_valid high for 1 cycle in the cycle after beat 4; dest_data lane 37 = 0x1025; dest_vcc = 64'hA5A5A5A5A5A5A5A5.
- Beats with 2-cycle gaps between them. Required response: pass_cnt steps 1,2,3,0; out_valid only after the 4th beat; assembled value identical to the back-to-back case.
- Hold out_ready=0 for 5 cycles after completion. Required response: outputs stable throughout. Then inject a beat with out_ready=0: drop_err=1 and dest_data unchanged.
- At completion, raise out_ready together with the first beat of the next wavefront. Required response: no drop; next word completes 4 cycles later with the new values in slice 0.
- collect_flush after 2 beats. Required response: IDLE, pass_cnt=0. Then 4 new beats: out_valid with only the new data in all four slices.
- Assert rst during COLLECT (pass_cnt=2) and during HOLD. Required response: next cycle all outputs 0, state IDLE, drop_err=0.
